// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one quick_spi master between NUM_REQ requesters.
// Latches the winner's command, runs the enable/start handshake, returns rx data and done/err pulses.
module spi_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned RX_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*2-1:0]           req_slave,
    input  logic [NUM_REQ-1:0]             req_op,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic [NUM_REQ-1:0]             err,
    output logic [RX_WIDTH-1:0]            rx_data,
    output logic                           spi_enable,
    output logic                           spi_start,
    output logic [1:0]                     spi_slave,
    output logic [DATA_WIDTH-1:0]          spi_outgoing,
    output logic                           spi_operation,
    input  logic                           spi_eot,
    input  logic [RX_WIDTH-1:0]            spi_incoming
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [PTR_W-1:0]      ptr, ptr_nxt;
    logic [PTR_W-1:0]      owner, owner_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [NUM_REQ-1:0]    grant_nxt, done_nxt, err_nxt;
    logic [RX_WIDTH-1:0]   rx_nxt;
    logic                  enable_nxt, start_nxt, op_nxt;
    logic [1:0]            slave_nxt;
    logic [DATA_WIDTH-1:0] outgoing_nxt;

    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W-1:0]      cand;

    // (base + off) mod NUM_REQ, both operands already below NUM_REQ
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // First active requester scanning ptr, ptr+1, ... with wrap-around
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            grant         <= '0;
            done          <= '0;
            err           <= '0;
            rx_data       <= '0;
            spi_enable    <= 1'b0;
            spi_start     <= 1'b0;
            spi_slave     <= '0;
            spi_outgoing  <= '0;
            spi_operation <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            owner         <= owner_nxt;
            cnt           <= cnt_nxt;
            grant         <= grant_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
            rx_data       <= rx_nxt;
            spi_enable    <= enable_nxt;
            spi_start     <= start_nxt;
            spi_slave     <= slave_nxt;
            spi_outgoing  <= outgoing_nxt;
            spi_operation <= op_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        cnt_nxt      = cnt;
        grant_nxt    = grant;
        done_nxt     = '0;
        err_nxt      = '0;
        rx_nxt       = rx_data;
        enable_nxt   = spi_enable;
        start_nxt    = 1'b0;
        slave_nxt    = spi_slave;
        outgoing_nxt = spi_outgoing;
        op_nxt       = spi_operation;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    grant_nxt          = '0;
                    grant_nxt[win_idx] = 1'b1;
                    owner_nxt          = win_idx;
                    outgoing_nxt       = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    slave_nxt          = req_slave[win_idx*2 +: 2];
                    op_nxt             = req_op[win_idx];
                    enable_nxt         = 1'b1;
                    start_nxt          = 1'b1;
                    state_nxt          = S_START;
                end
            end
            S_START: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                cnt_nxt = cnt + 1'b1;
                // Completion takes priority over a coincident timeout
                if (spi_eot) begin
                    rx_nxt     = spi_incoming;
                    done_nxt   = grant;
                    ptr_nxt    = wrap_add(owner, 1);
                    enable_nxt = 1'b0;
                    state_nxt  = S_DONE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_nxt    = grant;
                    ptr_nxt    = wrap_add(owner, 1);
                    enable_nxt = 1'b0;
                    state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                grant_nxt  = '0;
                enable_nxt = 1'b0;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized scoreboard bench for spi_bus_arbiter: a driver plays requesters and SPI master,
// a monitor compares each start and each done/err pulse against queued expectations.
module tb_spi_bus_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 8;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [2*N-1:0]    req_slave = '0;
    logic [N-1:0]      req_op = '0;
    logic [N-1:0]      grant, done, err;
    logic [RW-1:0]     rx_data;
    logic              spi_enable, spi_start, spi_operation;
    logic [1:0]        spi_slave;
    logic [DW-1:0]     spi_outgoing;
    logic              spi_eot = 1'b0;
    logic [RW-1:0]     spi_incoming = '0;

    spi_bus_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .RX_WIDTH(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req(req), .req_data(req_data), .req_slave(req_slave), .req_op(req_op),
        .grant(grant), .done(done), .err(err), .rx_data(rx_data),
        .spi_enable(spi_enable), .spi_start(spi_start), .spi_slave(spi_slave),
        .spi_outgoing(spi_outgoing), .spi_operation(spi_operation),
        .spi_eot(spi_eot), .spi_incoming(spi_incoming)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  grant;
        logic [1:0]    slave;
        logic          op;
        logic [DW-1:0] data;
        bit            is_err;
        logic [RW-1:0] rx;
        int            lat;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            ptr_m = 0;
    logic [RW-1:0] last_rx = '0;
    int            cyc = 0;
    int            start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing required=present", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks command at spi_start and response at done/err against queue head
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n) begin
            chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("resp_onehot0", 32'($onehot0(done | err)), 32'd1);
            if (spi_start) begin
                if (q.size() == 0) begin
                    fail_now("start_expected_entry");
                end else begin
                    chk("start_grant", 32'(grant), 32'(q[0].grant));
                    chk("start_slave", 32'(spi_slave), 32'(q[0].slave));
                    chk("start_op", 32'(spi_operation), 32'(q[0].op));
                    chk("start_data", 32'(spi_outgoing), 32'(q[0].data));
                    chk("start_enable", 32'(spi_enable), 32'd1);
                    start_cyc = cyc;
                end
            end
            if ((done | err) != '0) begin
                if (q.size() == 0) begin
                    fail_now("resp_expected_entry");
                end else begin
                    e = q.pop_front();
                    chk("done", 32'(done), e.is_err ? 32'd0 : 32'(e.grant));
                    chk("err", 32'(err), e.is_err ? 32'(e.grant) : 32'd0);
                    chk("rx_data", 32'(rx_data), 32'(e.rx));
                    chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
                    chk("enable_low", 32'(spi_enable), 32'd0);
                    chk("data_held", 32'(spi_outgoing), 32'(e.data));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic [1:0] s, input logic o);
        req[i] = 1'b1;
        req_data[i*DW +: DW] = d;
        req_slave[2*i +: 2] = s;
        req_op[i] = o;
    endtask

    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            if (req[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    // Push the reference expectation for the upcoming arbitration; returns winner
    task automatic push_expect(input int j, input logic [RW-1:0] inc, output int w);
        exp_t e;
        w = pick_winner();
        if (w < 0) begin
            fail_now("issue_request");
            return;
        end
        e.grant = '0;
        e.grant[w] = 1'b1;
        e.slave = req_slave[2*w +: 2];
        e.op = req_op[w];
        e.data = req_data[w*DW +: DW];
        e.is_err = (j == 0);
        e.rx = (j == 0) ? last_rx : inc;
        e.lat = (j == 0) ? int'(TO) + 1 : j + 1;
        q.push_back(e);
        last_rx = e.rx;
        ptr_m = (w + 1) % N;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int t = 0; t < 6 && !found; t++) begin
            @(posedge clk); #1;
            if (spi_start) found = 1'b1;
        end
        if (!found) fail_now("start_timeout");
    endtask

    // One transaction: j = WAIT cycle carrying eot (1..TO), 0 = never (timeout)
    task automatic issue(input int j, input logic [RW-1:0] inc, input bit keep, output int w);
        bit found;
        int last_c;
        push_expect(j, inc, w);
        if (w < 0) return;
        wait_start(found);
        if (!found) begin
            q.delete();
            return;
        end
        spi_eot = 1'($urandom_range(0, 1));
        spi_incoming = RW'($urandom);
        last_c = (j == 0) ? int'(TO) : j;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk); #1;
            spi_eot = (c == j);
            spi_incoming = (c == j) ? inc : RW'($urandom);
            if (c == 1 && !keep && $urandom_range(0, 3) == 0) req[w] = 1'b0;
            if (c == 1 && $urandom_range(0, 3) == 0) req_data = (N*DW)'({$urandom, $urandom});
        end
        @(posedge clk); #1;
        spi_eot = 1'($urandom_range(0, 1));
        spi_incoming = RW'($urandom);
        chk("txn_finished", 32'(|(done | err)), 32'd1);
        if (!keep) req[w] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_enable"}, 32'(spi_enable), 32'd0);
        chk({tag, "_start"}, 32'(spi_start), 32'd0);
        chk({tag, "_slave"}, 32'(spi_slave), 32'd0);
        chk({tag, "_outgoing"}, 32'(spi_outgoing), 32'd0);
        chk({tag, "_op"}, 32'(spi_operation), 32'd0);
    endtask

    task automatic add_random_reqs();
        for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 1) == 1)
                set_req(i, DW'($urandom), 2'($urandom), 1'($urandom));
        end
        if (req == '0)
            set_req(int'($urandom_range(0, N - 1)), DW'($urandom), 2'($urandom), 1'($urandom));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin : driver
        int w;
        int j;
        int r;
        bit found;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single requester, known command
        set_req(0, 16'h1305, 2'd0, 1'b1);
        issue(3, 8'hA5, 1'b0, w);

        // Both held continuously: grants must alternate
        set_req(0, 16'h2211, 2'd1, 1'b0);
        set_req(1, 16'h4433, 2'd2, 1'b1);
        for (int n = 0; n < 4; n++) issue(int'($urandom_range(1, TO - 1)), RW'($urandom), 1'b1, w);
        req = '0;

        // Lone requester 1, then contention
        set_req(1, 16'h5A5A, 2'd3, 1'b0);
        issue(2, 8'h11, 1'b0, w);
        set_req(0, 16'h0F0F, 2'd1, 1'b1);
        set_req(1, 16'hF0F0, 2'd2, 1'b0);
        issue(1, 8'h22, 1'b0, w);
        req = '0;

        // Timeout without eot, then eot on the timeout cycle
        set_req(0, 16'h7777, 2'd2, 1'b1);
        issue(0, 8'h00, 1'b0, w);
        set_req(1, 16'h8888, 2'd1, 1'b0);
        issue(TO, 8'h5C, 1'b0, w);
        req = '0;

        // Reset in the middle of WAIT
        set_req(0, 16'h9999, 2'd3, 1'b1);
        push_expect(0, 8'h00, w);
        wait_start(found);
        spi_eot = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("midreset");
        q.delete();
        ptr_m = 0;
        last_rx = '0;
        req = '0;
        reset_n = 1'b1;
        set_req(0, 16'hBEEF, 2'd2, 1'b0);
        issue(2, 8'h3C, 1'b0, w);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if (req == '0) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            add_random_reqs();
            r = int'($urandom_range(0, 9));
            if (r == 0) j = 0;
            else if (r == 1) j = int'(TO);
            else j = int'($urandom_range(1, TO - 1));
            issue(j, RW'($urandom), 1'b0, w);
        end
        req = '0;
        spi_eot = 1'b0;

        repeat (4) begin @(posedge clk); #1; end
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
